// File: rtl/gf_mul_sched.sv
// Two-requester round-robin scheduler in front of a GF(2^M) systolic multiplier.
// Defining GF_MUL_SCHED_TIMEOUT_EN bounds the WAIT state to TMO cycles.
module gf_mul_sched #(
    parameter int unsigned M   = 7,
    parameter int unsigned TMO = 2 * M + 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [M:0]   f_i,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [M-1:0] a0_i,
    input  logic [M-1:0] b0_i,
    input  logic [M-1:0] a1_i,
    input  logic [M-1:0] b1_i,
    output logic         ack0_o,
    output logic         ack1_o,
    output logic [M-1:0] c_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         mul_start_o,
    output logic [M-1:0] mul_a_o,
    output logic [M-1:0] mul_b_o,
    output logic [M:0]   mul_f_o,
    input  logic [M-1:0] mul_c_i,
    input  logic         mul_over_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e       state_q;
    logic         ptr_q;
    logic         id_q;
    logic         ack0_q;
    logic         ack1_q;
    logic         err_q;
    logic         busy_q;
    logic         start_q;
    logic [M-1:0] c_q;
    logic [M-1:0] a_q;
    logic [M-1:0] b_q;
    logic [M:0]   f_q;
    logic         gnt;

    // Pointer only arbitrates a tie; a lone request wins outright.
    assign gnt = (req0_i && req1_i) ? ptr_q : req1_i;

`ifdef GF_MUL_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    logic [CntW-1:0] cnt_q;
    logic            tmo_hit;
    assign tmo_hit = (cnt_q == CntW'(TMO - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            c_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
`ifdef GF_MUL_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0_i || req1_i) begin
                        id_q   <= gnt;
                        a_q    <= gnt ? a1_i : a0_i;
                        b_q    <= gnt ? b1_i : b0_i;
                        f_q    <= f_i;
                        busy_q <= 1'b1;
                        if (f_i[M]) begin
                            state_q <= StIssue;
                            start_q <= 1'b1;
                        end else begin
                            // Degenerate polynomial: report failure without using the multiplier.
                            state_q <= StDone;
                            c_q     <= '0;
                            err_q   <= 1'b1;
                            ack0_q  <= ~gnt;
                            ack1_q  <= gnt;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
`ifdef GF_MUL_SCHED_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWait: begin
                    if (mul_over_i) begin
                        state_q <= StDone;
                        c_q     <= mul_c_i;
                        err_q   <= 1'b0;
                        ack0_q  <= ~id_q;
                        ack1_q  <= id_q;
                    end
`ifdef GF_MUL_SCHED_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q <= StDone;
                        c_q     <= '0;
                        err_q   <= 1'b1;
                        ack0_q  <= ~id_q;
                        ack1_q  <= id_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ptr_q   <= ~id_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign c_o         = c_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign mul_start_o = start_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign mul_f_o     = f_q;

endmodule

// File: tb/tb_gf_mul_sched.sv
// Randomized bench for gf_mul_sched: transaction-age reference model, stub multiplier, directed cases.
// Timeout expectations follow GF_MUL_SCHED_TIMEOUT_EN.
module tb_gf_mul_sched;

    localparam int TMO = 18;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] f_i = 8'h83;
    logic       req0_i = 1'b0;
    logic       req1_i = 1'b0;
    logic [6:0] a0_i = '0;
    logic [6:0] b0_i = '0;
    logic [6:0] a1_i = '0;
    logic [6:0] b1_i = '0;
    logic       ack0_o;
    logic       ack1_o;
    logic [6:0] c_o;
    logic       err_o;
    logic       busy_o;
    logic       mul_start_o;
    logic [6:0] mul_a_o;
    logic [6:0] mul_b_o;
    logic [7:0] mul_f_o;
    logic [6:0] mul_c_i = '0;
    logic       mul_over_i = 1'b0;

    gf_mul_sched #(
        .M  (7),
        .TMO(TMO)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .f_i        (f_i),
        .req0_i     (req0_i),
        .req1_i     (req1_i),
        .a0_i       (a0_i),
        .b0_i       (b0_i),
        .a1_i       (a1_i),
        .b1_i       (b1_i),
        .ack0_o     (ack0_o),
        .ack1_o     (ack1_o),
        .c_o        (c_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .mul_start_o(mul_start_o),
        .mul_a_o    (mul_a_o),
        .mul_b_o    (mul_b_o),
        .mul_f_o    (mul_f_o),
        .mul_c_i    (mul_c_i),
        .mul_over_i (mul_over_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] gf_mul(input logic [6:0] a, input logic [6:0] b,
                                          input logic [7:0] f);
        logic [13:0] p;
        p = '0;
        for (int i = 0; i < 7; i++) if (b[i]) p = p ^ (14'(a) << i);
        for (int i = 13; i >= 7; i--) if (p[i]) p = p ^ (14'(f) << (i - 7));
        return p[6:0];
    endfunction

    // Reference model: a transaction is described by its age in cycles since grant
    // and the age at which its ack is due (-1 while still unknown).
    int         m_age = -1;
    int         m_done = -1;
    bit         m_good = 1'b0;
    bit         m_win = 1'b0;
    bit         m_fav = 1'b0;
    bit         m_err = 1'b0;
    logic [6:0] m_a = '0;
    logic [6:0] m_b = '0;
    logic [6:0] m_c = '0;
    logic [7:0] m_f = '0;

    initial begin : model
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_age = -1; m_done = -1; m_good = 0; m_win = 0; m_fav = 0; m_err = 0;
                m_a = '0; m_b = '0; m_c = '0; m_f = '0;
            end else if (m_age < 0) begin
                if (req0_i || req1_i) begin
                    m_win  = (req0_i && req1_i) ? m_fav : req1_i;
                    m_a    = m_win ? a1_i : a0_i;
                    m_b    = m_win ? b1_i : b0_i;
                    m_f    = f_i;
                    m_good = f_i[7];
                    m_age  = 0;
                    if (m_good) m_done = -1;
                    else begin
                        m_done = 0; m_c = '0; m_err = 1;
                    end
                end
            end else if (m_age == m_done) begin
                m_age = -1;
                m_fav = !m_win;
            end else begin
                if (m_age >= 1 && mul_over_i) begin
                    m_done = m_age + 1; m_c = mul_c_i; m_err = 0;
                end
`ifdef GF_MUL_SCHED_TIMEOUT_EN
                else if (m_age == TMO) begin
                    m_done = m_age + 1; m_c = '0; m_err = 1;
                end
`endif
                m_age++;
            end
        end
    end

    initial begin : compare
        bit ack_exp;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                ack_exp = (m_age >= 0) && (m_age == m_done);
                chk("busy", 32'(busy_o), 32'(m_age >= 0));
                chk("mul_start", 32'(mul_start_o), 32'(m_age == 0 && m_good));
                chk("ack0", 32'(ack0_o), 32'(ack_exp && !m_win));
                chk("ack1", 32'(ack1_o), 32'(ack_exp && m_win));
                chk("c", 32'(c_o), 32'(m_c));
                chk("mul_a", 32'(mul_a_o), 32'(m_a));
                chk("mul_b", 32'(mul_b_o), 32'(m_b));
                chk("mul_f", 32'(mul_f_o), 32'(m_f));
                if (ack_exp) chk("err", 32'(err_o), 32'(m_err));
            end
        end
    end

    // Stub multiplier: mul_over one cycle, 7 cycles after mul_start; optional stray strobes.
    bit         stub_on = 1'b1;
    bit         stub_const = 1'b1;
    bit         glitch_en = 1'b0;
    int         st_cnt = 0;
    logic [6:0] st_val = '0;

    initial begin : stub
        forever begin
            @(posedge clk_i);
            #1;
            mul_over_i = 1'b0;
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0 && stub_on) begin
                    mul_over_i = 1'b1;
                    mul_c_i    = st_val;
                end
            end
            if (mul_start_o) begin
                st_cnt = 7;
                st_val = stub_const ? 7'h15 : gf_mul(mul_a_o, mul_b_o, mul_f_o);
            end else if (glitch_en && st_cnt == 0 && !mul_over_i &&
                         $urandom_range(0, 7) == 0) begin
                mul_over_i = 1'b1;
                mul_c_i    = 7'($urandom);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic outputs_zero(input string tag);
        chk({tag, "_ctl"}, 32'({ack0_o, ack1_o, err_o, busy_o, mul_start_o}), 32'd0);
        chk({tag, "_c"}, 32'(c_o), 32'd0);
        chk({tag, "_mul_a"}, 32'(mul_a_o), 32'd0);
        chk({tag, "_mul_b"}, 32'(mul_b_o), 32'd0);
        chk({tag, "_mul_f"}, 32'(mul_f_o), 32'd0);
    endtask

    task automatic pulse_reset();
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin : main
        int  n_start;
        int  n_ack1;
        int  t_start;
        int  cnt;
        int  gap;
        int  n_acks;
        int  n_stray;
        bit  got;
        bit  order [4];

        chk("gf_x_times_x6", 32'(gf_mul(7'h02, 7'h40, 8'h83)), 32'h03);
        chk("gf_x6_squared", 32'(gf_mul(7'h40, 7'h40, 8'h83)), 32'h60);

        #3 outputs_zero("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Single request with fixed operands.
        @(negedge clk_i);
        a0_i = 7'b1010101; b0_i = 7'b1101010; req0_i = 1'b1;
        n_start = 0; n_ack1 = 0; t_start = -100; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (ack1_o) n_ack1++;
            if (mul_start_o) begin
                n_start++; t_start = i;
                chk("t1_mul_a", 32'(mul_a_o), 32'h55);
                chk("t1_mul_b", 32'(mul_b_o), 32'h6a);
                chk("t1_mul_f", 32'(mul_f_o), 32'h83);
            end
            if (ack0_o) begin
                got = 1;
                req0_i = 1'b0;
                chk("t1_c", 32'(c_o), 32'h15);
                chk("t1_err", 32'(err_o), 32'd0);
                chk("t1_ack_latency", 32'(i - t_start), 32'd8);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (ack1_o) n_ack1++;
        end
        chk("t1_ack_seen", 32'(got), 32'd1);
        chk("t1_start_count", 32'(n_start), 32'd1);
        chk("t1_no_ack1", 32'(n_ack1), 32'd0);

        // Both requesters held high from reset.
        req0_i = 1'b1; req1_i = 1'b1;
        pulse_reset();
        cnt = 0; gap = 0;
        for (int i = 0; i < 100 && cnt < 4; i++) begin
            @(negedge clk_i);
            if (!busy_o) gap++;
            if (ack0_o || ack1_o) begin
                order[cnt] = ack1_o;
                if (cnt > 0) chk("t2_idle_gap", 32'(gap), 32'd1);
                gap = 0;
                cnt++;
            end
        end
        req0_i = 1'b0; req1_i = 1'b0;
        chk("t2_ack_count", 32'(cnt), 32'd4);
        chk("t2_order0", 32'(order[0]), 32'd0);
        chk("t2_order1", 32'(order[1]), 32'd1);
        chk("t2_order2", 32'(order[2]), 32'd0);
        chk("t2_order3", 32'(order[3]), 32'd1);
        repeat (2) @(negedge clk_i);

        // Polynomial without its top term.
        f_i = 8'b00000011; a1_i = 7'($urandom); b1_i = 7'($urandom); req1_i = 1'b1;
        n_start = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (mul_start_o) n_start++;
            if (ack1_o) begin
                got = 1;
                req1_i = 1'b0;
                chk("t3_ack_delay", 32'(i), 32'd0);
                chk("t3_err", 32'(err_o), 32'd1);
                chk("t3_c", 32'(c_o), 32'd0);
            end
        end
        req1_i = 1'b0;
        f_i = 8'h83;
        chk("t3_ack_seen", 32'(got), 32'd1);
        chk("t3_no_start", 32'(n_start), 32'd0);
        repeat (2) @(negedge clk_i);

        // Multiplier that never completes.
        stub_on = 1'b0;
        req0_i = 1'b1;
        t_start = -100; got = 0; cnt = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_i);
            if (mul_start_o) t_start = i;
            if (ack0_o) begin
                got = 1;
                cnt = i - t_start;
                req0_i = 1'b0;
`ifdef GF_MUL_SCHED_TIMEOUT_EN
                chk("t4_err", 32'(err_o), 32'd1);
                chk("t4_c", 32'(c_o), 32'd0);
`endif
            end
        end
        req0_i = 1'b0;
`ifdef GF_MUL_SCHED_TIMEOUT_EN
        chk("t4_ack_seen", 32'(got), 32'd1);
        chk("t4_wait_cycles", 32'(cnt - 1), 32'(TMO));
        repeat (2) @(negedge clk_i);
`else
        chk("t4_no_ack", 32'(got), 32'd0);
        chk("t4_still_busy", 32'(busy_o), 32'd1);
        pulse_reset();
`endif
        stub_on = 1'b1;
        @(negedge clk_i);

        // Reset in WAIT, then a stray completion strobe.
        a0_i = 7'($urandom); b0_i = 7'($urandom); req0_i = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (mul_start_o) got = 1;
        end
        chk("t5_start_seen", 32'(got), 32'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        req0_i = 1'b0;
        #1 outputs_zero("t5_async");
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_acks = 0; n_stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (ack0_o || ack1_o) n_acks++;
            if (mul_over_i) n_stray++;
        end
        chk("t5_no_ack", 32'(n_acks), 32'd0);
        chk("t5_stray_seen", 32'(n_stray), 32'd1);
        a0_i = 7'($urandom); b0_i = 7'($urandom); req0_i = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (ack0_o) begin
                got = 1;
                req0_i = 1'b0;
                chk("t5_c", 32'(c_o), 32'h15);
                chk("t5_err", 32'(err_o), 32'd0);
            end
        end
        req0_i = 1'b0;
        chk("t5_ack_seen", 32'(got), 32'd1);

        // Random traffic with true products, stray strobes, bad polynomials, operand churn.
        stub_const = 1'b0;
        glitch_en = 1'b1;
        n_acks = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            if (ack0_o || ack1_o) n_acks++;
            if (req0_i ? (ack0_o && $urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0))
                req0_i = !req0_i;
            if (req1_i ? (ack1_o && $urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0))
                req1_i = !req1_i;
            if ($urandom_range(0, 3) == 0) begin
                a0_i = 7'($urandom); b0_i = 7'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                a1_i = 7'($urandom); b1_i = 7'($urandom);
            end
            f_i = {1'($urandom_range(0, 15) != 0), 7'($urandom)};
        end
        req0_i = 1'b0; req1_i = 1'b0;
        glitch_en = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("rand_progress", 32'(n_acks > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
